mul_result_stage: RTL
=====================

// Module: mul_result_stage
// PURPOSE
//  Registered output stage downstream of the 64-bit signed multiplier array.
//  Captures each Product with its op select and tag, then selects the low or high 32-bit half.
//  Computes zero/negative/overflow flags and buffers results in a small FIFO.
//  Presents results to the ALU writeback path over a valid/ready handshake.
// PARAMETERS
//  DEPTH   2   result FIFO entries; power of two, >= 2
//  TAG_W   4   width of the opaque tag carried alongside each product
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst_n         in   1      synchronous active-low reset
//  in_valid      in   1      upstream presents a product this cycle
//  in_ready      out  1      stage can accept a product this cycle
//  in_product    in   64     signed 2's-complement product from the multiplier
//  in_hi         in   1      0: return product[31:0], 1: return product[63:32]
//  in_tag        in   TAG_W  opaque tag, returned unchanged
//  out_valid     out  1      result available at FIFO head
//  out_ready     in   1      downstream accepts result this cycle
//  out_data      out  32     selected half
//  out_zero      out  1      out_data == 0
//  out_neg       out  1      out_data[31]
//  out_ovf       out  1      lo-select only: product does not fit in 32-bit signed
//  out_tag       out  TAG_W  tag of head entry
//  stall_cnt     out  16     saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Push when in_valid & in_ready; pop when out_valid & out_ready.
//  - Registered count, 0..DEPTH.
//  - in_ready  = rst_n & (count != DEPTH).
//  - out_valid = (count != 0), registered.
//  - Latency: a product pushed in cycle N is visible at out_* in cycle N+1; no combinational bypass.
//  - Per-entry flags are computed at push time and stored with the data:
//      data = in_hi ? product[63:32] : product[31:0]
//      zero = (data == 0); neg = data[31]
//      ovf  = !in_hi & (product[63:31] not all-ones and not all-zeros); ovf = 0 when in_hi = 1
//  - out_* fields are driven from the entry at rd_ptr.
//  - When empty, out_data/flags/tag read 0: entries are cleared on pop and at reset.
//  - Pointers wrap modulo DEPTH.
//  - Full: no push. A pop while full raises in_ready in the next cycle, not the same cycle.
//  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, ordering preserved.
//  - Simultaneous push and pop with count == 0 is impossible, because out_valid = 0.
//  - stall_cnt increments when out_valid & !out_ready, holds at 16'hFFFF, and is never cleared except by reset.
//  - Reset (rst_n = 0 at any edge, including mid-transfer):
//      count, pointers, entries and stall_cnt go to 0; out_valid = 0; all out_* fields = 0.
//      in_ready = 0 while rst_n is low and 1 in the first cycle after release.
//      In-flight entries are discarded.
//  - Upstream must hold in_product/in_hi/in_tag stable while in_valid & !in_ready.
//  - Downstream may drop out_ready at any time; the head entry holds until popped.
// TESTING
//  1. Reset, then push 64'hFFFFFFFF_FFFFFFFE, hi=0, tag=3
//     -> next cycle: out_data=FFFFFFFE, neg=1, zero=0, ovf=0, tag=3.
//  2. Push 64'h00000000_FFFFFFFE, hi=0 -> data=FFFFFFFE, ovf=1.
//     Push 64'h00000001_00000000, hi=0 -> data=0, zero=1, ovf=1.
//     Same product with hi=1 -> data=1, ovf=0.
//  3. Hold out_ready=0 and push 3 products (DEPTH=2):
//     -> in_ready falls after the 2nd push; the 3rd is held; stall_cnt counts.
//     Then raise out_ready -> results appear in push order, and in_ready returns one cycle after the first pop.
//  4. Steady stream, in_valid=out_ready=1 for 20 cycles with tags 0..F wrapping
//     -> one result per cycle, tags in order, no drops or duplicates.
//  5. Fill the FIFO, assert rst_n=0 for one cycle mid-stream
//     -> out_valid=0, out_data=0, stall_cnt=0; the next push after release emerges alone.
//  6. Hold out_ready=0 with the FIFO non-empty for 70000 cycles -> stall_cnt saturates at FFFF.

Source files
------------

// File: rtl/mul_result_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_result_if : product-in / result-out handshake bundle                  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mul_result_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_product;
    logic             in_hi;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      stall_cnt;

    modport slave (
        input  in_valid, in_product, in_hi, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, out_ovf,
               out_tag, stall_cnt
    );

    modport master (
        output in_valid, in_product, in_hi, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, out_ovf,
               out_tag, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mul_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_result_stage : half-select, flag and FIFO stage after the multiplier  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mul_result_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]      data;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [15:0]      stall_q;
    logic [15:0]      stall_d;
    logic             push;
    logic             pop;
    logic             out_valid;
    entry_t           new_entry;

    assign out_valid    = (count_q != '0);
    assign bus.in_ready = rst_n & (count_q != CNT_W'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = out_valid & bus.out_ready;

    // Flags are resolved at push time so the output path is a plain mux.
    always_comb begin
        new_entry      = '0;
        new_entry.data = bus.in_hi ? bus.in_product[63:32] : bus.in_product[31:0];
        new_entry.zero = (new_entry.data == 32'd0);
        new_entry.neg  = new_entry.data[31];
        new_entry.ovf  = !bus.in_hi & !(&bus.in_product[63:31]) & (|bus.in_product[63:31]);
        new_entry.tag  = bus.in_tag;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        stall_d = stall_q;
        if (out_valid && !bus.out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            stall_q <= stall_d;
            // Popped slots are zeroed so an empty FIFO presents all-zero outputs.
            if (pop) begin
                mem_q[rd_ptr_q] <= '0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q].data;
    assign bus.out_zero  = mem_q[rd_ptr_q].zero;
    assign bus.out_neg   = mem_q[rd_ptr_q].neg;
    assign bus.out_ovf   = mem_q[rd_ptr_q].ovf;
    assign bus.out_tag   = mem_q[rd_ptr_q].tag;
    assign bus.stall_cnt = stall_q;
endmodule
`default_nettype wire
